// File: rtl/uart_program_loader_pkg.sv
// Shared types and helpers for the UART program loader: receiver state
// encoding and the bit-period calculation.
package uart_program_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq_hz, input int baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_program_loader_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// registered byte output with a one-cycle valid pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | line high, waiting for a falling edge
// START     | half a bit in, confirming the start bit (glitch filter)
// DATA      | sampling 8 data bits LSB first, one per bit period
// STOP      | sampling the stop bit; 1 delivers the byte
// WAIT_IDLE | framing error, waiting for the line to return high
module uart_rx
  import uart_program_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 694
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] FULL_LOAD = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_meta;
  logic            rx_sync;
  rx_state_t       state;
  logic [TW-1:0]   bit_timer;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Bit timer counts down; each state acts when it reaches zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      bit_timer  <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
    end else begin
      byte_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_sync) begin
            state     <= START;
            bit_timer <= HALF_LOAD;
          end
        end
        START: begin
          if (bit_timer == '0) begin
            if (!rx_sync) begin
              state     <= DATA;
              bit_timer <= FULL_LOAD;
              bit_idx   <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end
        DATA: begin
          if (bit_timer == '0) begin
            shift     <= {rx_sync, shift[7:1]};
            bit_timer <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end
        STOP: begin
          if (bit_timer == '0) begin
            if (rx_sync) begin
              byte_data  <= shift;
              byte_valid <= 1'b1;
              state      <= IDLE;
            end else begin
              state <= WAIT_IDLE;
            end
          end else begin
            bit_timer <= bit_timer - TW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_sync) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Serial program loader: packs received bytes MSB-first into 32-bit words,
// writes them sequentially into program memory, and serves fetch reads.
module uart_program_loader
  import uart_program_loader_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 80_000_000,
  parameter int BAUD        = 115200,
  parameter int MEM_WORDS   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_enable,
  input  logic        rx,
  input  logic [31:0] read_address,
  output logic [31:0] read_data,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word_data,
  output logic [31:0] word_address
);

  localparam int          CPB      = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int          AW       = $clog2(MEM_WORDS);
  localparam logic [31:0] PTR_LAST = 32'(MEM_WORDS * 4 - 4);

  logic [1:0]  byte_count;
  logic [23:0] word_shift;
  logic [31:0] wr_ptr;
  logic [31:0] mem [MEM_WORDS];

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{read_address[31:AW+2], read_address[1:0]};

  uart_rx #(
    .CLKS_PER_BIT(CPB)
  ) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .byte_data (byte_data)
  );

  // Only the three earlier bytes are kept; the fourth arrives with byte_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_count   <= '0;
      word_shift   <= '0;
      wr_ptr       <= '0;
      word_valid   <= 1'b0;
      word_data    <= '0;
      word_address <= '0;
    end else begin
      word_valid <= 1'b0;
      if (!load_enable) begin
        byte_count <= '0;
        wr_ptr     <= '0;
      end else if (byte_valid) begin
        word_shift <= {word_shift[15:0], byte_data};
        byte_count <= byte_count + 2'd1;
        if (byte_count == 2'd3) begin
          word_data    <= {word_shift, byte_data};
          word_address <= wr_ptr;
          word_valid   <= 1'b1;
          wr_ptr       <= (wr_ptr == PTR_LAST) ? 32'd0 : wr_ptr + 32'd4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (word_valid) begin
      mem[word_address[AW+1:2]] <= word_data;
    end
  end

  // Read-before-write: a same-word collision returns the old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_data <= '0;
    end else begin
      read_data <= mem[read_address[AW+1:2]];
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader at a reduced bit period (80 clocks).
module tb_uart_program_loader;
  import uart_program_loader_pkg::*;

  localparam int CLK_FREQ_HZ = 80_000_000;
  localparam int BAUD        = 1_000_000;
  localparam int MEM_WORDS   = 1024;
  localparam int CPB         = 80;

  logic        clk;
  logic        reset;
  logic        load_enable;
  logic        rx;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        word_valid;
  logic [31:0] word_data;
  logic [31:0] word_address;

  uart_program_loader #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ),
    .BAUD       (BAUD),
    .MEM_WORDS  (MEM_WORDS)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_enable (load_enable),
    .rx          (rx),
    .read_address(read_address),
    .read_data   (read_data),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_address(word_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cycle_cnt = 0;
  int t_fall = 0;
  int t_bv = 0;
  logic [7:0]  byte_q [$];
  logic [31:0] wdata_q [$];
  logic [31:0] waddr_q [$];
  logic        wv_d = 1'b0;
  logic [31:0] rd_after_write = 32'h0;

  always @(posedge clk) cycle_cnt++;

  always @(negedge clk) begin
    if (byte_valid) begin
      byte_q.push_back(byte_data);
      t_bv = cycle_cnt;
    end
    if (word_valid) begin
      wdata_q.push_back(word_data);
      waddr_q.push_back(word_address);
    end
    if (wv_d) rd_after_write = read_data;
    wv_d = word_valid;
  end

  function automatic logic [7:0] bq(input int i);
    if (i < byte_q.size()) return byte_q[i];
    return 8'hxx;
  endfunction

  function automatic logic [31:0] wd(input int i);
    if (i < wdata_q.size()) return wdata_q[i];
    return 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] wa(input int i);
    if (i < waddr_q.size()) return waddr_q[i];
    return 32'hxxxxxxxx;
  endfunction

  task automatic clear_caps();
    byte_q.delete();
    wdata_q.delete();
    waddr_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(posedge clk); #1;
    rx = 1'b0;
    t_fall = cycle_cnt;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic read_word(input logic [31:0] addr, input logic [31:0] exp, input string name);
    @(posedge clk); #1;
    read_address = addr;
    @(posedge clk); #1;
    total++;
    if (read_data !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, read_data, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    load_enable = 1'b0;
    read_address = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (byte_valid !== 1'b0) begin bad++; $display("FAIL reset_byte_valid: got %b expected 0", byte_valid); end
    total++; if (word_valid !== 1'b0) begin bad++; $display("FAIL reset_word_valid: got %b expected 0", word_valid); end
    total++; if (byte_data !== 8'h00) begin bad++; $display("FAIL reset_byte_data: got %h expected 00", byte_data); end
    total++; if (word_data !== 32'h0) begin bad++; $display("FAIL reset_word_data: got %h expected 0", word_data); end
    total++; if (word_address !== 32'h0) begin bad++; $display("FAIL reset_word_address: got %h expected 0", word_address); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL reset_read_data: got %h expected 0", read_data); end
    total++; if (dut.u_rx.state !== IDLE) begin bad++; $display("FAIL reset_rx_state: got %0d expected IDLE", dut.u_rx.state); end
    reset = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_load_program();
    logic [7:0] prog [8] = '{8'h00, 8'h40, 8'h00, 8'h93, 8'h00, 8'h80, 8'h01, 8'h13};
    load_enable = 1'b1;
    clear_caps();
    for (int i = 0; i < 8; i++) send_byte(prog[i], 1'b1);
    total++; if (byte_q.size() != 8) begin bad++; $display("FAIL load_byte_count: got %0d expected 8", byte_q.size()); end
    total++; if (wdata_q.size() != 2) begin bad++; $display("FAIL load_word_count: got %0d expected 2", wdata_q.size()); end
    total++; if (wd(0) !== 32'h00400093) begin bad++; $display("FAIL load_word0_data: got %h expected 00400093", wd(0)); end
    total++; if (wa(0) !== 32'h0) begin bad++; $display("FAIL load_word0_addr: got %h expected 0", wa(0)); end
    total++; if (wd(1) !== 32'h00800113) begin bad++; $display("FAIL load_word1_data: got %h expected 00800113", wd(1)); end
    total++; if (wa(1) !== 32'h4) begin bad++; $display("FAIL load_word1_addr: got %h expected 4", wa(1)); end
    read_word(32'h0, 32'h00400093, "read_addr0");
    read_word(32'h6, 32'h00800113, "read_addr6");
    read_word(32'h1004, 32'h00800113, "read_alias_1004");
  endtask

  task automatic test_framing_error();
    clear_caps();
    send_byte(8'h55, 1'b0);
    total++; if (byte_q.size() != 0) begin bad++; $display("FAIL frame_err_no_byte: got %0d expected 0", byte_q.size()); end
    total++; if (byte_data !== 8'h13) begin bad++; $display("FAIL frame_err_byte_held: got %h expected 13", byte_data); end
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h78, 1'b1);
    total++; if (bq(0) !== 8'h12) begin bad++; $display("FAIL frame_recover_byte: got %h expected 12", bq(0)); end
    total++; if (wdata_q.size() != 1) begin bad++; $display("FAIL frame_word_count: got %0d expected 1", wdata_q.size()); end
    total++; if (wd(0) !== 32'h12345678) begin bad++; $display("FAIL frame_word_data: got %h expected 12345678", wd(0)); end
    total++; if (wa(0) !== 32'h8) begin bad++; $display("FAIL frame_word_addr: got %h expected 8", wa(0)); end
  endtask

  task automatic test_latency();
    int lat;
    load_enable = 1'b0;
    clear_caps();
    send_byte(8'hA5, 1'b1);
    lat = t_bv - t_fall;
    total++; if (byte_q.size() != 1) begin bad++; $display("FAIL latency_byte_count: got %0d expected 1", byte_q.size()); end
    total++; if (bq(0) !== 8'hA5) begin bad++; $display("FAIL latency_byte_data: got %h expected a5", bq(0)); end
    total++; if (lat < 757 || lat > 763) begin bad++; $display("FAIL latency_cycles: got %0d expected 757..763", lat); end
  endtask

  task automatic test_glitch();
    clear_caps();
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (CPB) @(posedge clk);
    #1;
    total++; if (byte_q.size() != 0) begin bad++; $display("FAIL glitch_no_byte: got %0d expected 0", byte_q.size()); end
    total++; if (dut.u_rx.state !== IDLE) begin bad++; $display("FAIL glitch_state: got %0d expected IDLE", dut.u_rx.state); end
    send_byte(8'h3C, 1'b1);
    total++; if (byte_q.size() != 1) begin bad++; $display("FAIL glitch_after_count: got %0d expected 1", byte_q.size()); end
    total++; if (bq(0) !== 8'h3C) begin bad++; $display("FAIL glitch_after_data: got %h expected 3c", bq(0)); end
  endtask

  task automatic test_load_disable();
    load_enable = 1'b0;
    clear_caps();
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    total++; if (byte_q.size() != 4) begin bad++; $display("FAIL disable_byte_count: got %0d expected 4", byte_q.size()); end
    total++; if (wdata_q.size() != 0) begin bad++; $display("FAIL disable_word_count: got %0d expected 0", wdata_q.size()); end
    read_word(32'h0, 32'h00400093, "disable_mem0_kept");
    load_enable = 1'b1;
    clear_caps();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    total++; if (wdata_q.size() != 1) begin bad++; $display("FAIL enable_word_count: got %0d expected 1", wdata_q.size()); end
    total++; if (wd(0) !== 32'h11223344) begin bad++; $display("FAIL enable_word_data: got %h expected 11223344", wd(0)); end
    total++; if (wa(0) !== 32'h0) begin bad++; $display("FAIL enable_word_addr: got %h expected 0", wa(0)); end
    read_word(32'h0, 32'h11223344, "enable_mem0");
  endtask

  task automatic test_reset_mid_word();
    load_enable = 1'b1;
    read_address = 32'h0;
    clear_caps();
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    rd_after_write = 32'h0;
    clear_caps();
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    total++; if (wdata_q.size() != 1) begin bad++; $display("FAIL rst_word_count: got %0d expected 1", wdata_q.size()); end
    total++; if (wd(0) !== 32'hAABBCCDD) begin bad++; $display("FAIL rst_word_data: got %h expected aabbccdd", wd(0)); end
    total++; if (wa(0) !== 32'h0) begin bad++; $display("FAIL rst_word_addr: got %h expected 0", wa(0)); end
    total++; if (rd_after_write !== 32'h11223344) begin bad++; $display("FAIL rst_read_during_write: got %h expected 11223344", rd_after_write); end
    total++; if (read_data !== 32'hAABBCCDD) begin bad++; $display("FAIL rst_read_new: got %h expected aabbccdd", read_data); end
  endtask

  initial begin
    test_reset();
    test_load_program();
    test_framing_error();
    test_latency();
    test_glitch();
    test_load_disable();
    test_reset_mid_word();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Loads a program image over a serial line into an instruction memory.
- Receives 8N1 UART bytes and packs every four consecutive bytes, most significant byte first, into a 32-bit instruction word.
- Writes each completed word to an internal word-addressed program memory at sequential byte addresses 0, 4, 8, …
- The CPU fetch path reads the same memory through a synchronous read port.
- Sits between the board RX pin and the core's instruction fetch.

Parameters:
CLK_FREQ_HZ, 80_000_000, system clock frequency in Hz.
BAUD, 115200, serial bit rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD, integer division; 694 at the defaults.
MEM_WORDS, 1024, memory depth in 32-bit words; must be a power of two.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
load_enable  in  1  1 = accept serial data and write memory.
rx  in  1  UART receive line; idles high; asynchronous to clk.
read_address  in  32  fetch byte address; bits [1:0] are ignored.
read_data  out  32  memory word, registered.
byte_valid  out  1  one-cycle pulse when a received byte is valid.
byte_data  out  8  received byte; holds its value until the next byte.
word_valid  out  1  one-cycle pulse when a word is complete; this pulse is the memory write strobe.
word_data  out  32  assembled word; held until the next word.
word_address  out  32  byte address of the word flagged by word_valid.

Behaviour:
- Reset (synchronous): byte_valid = 0, word_valid = 0, byte_data = 0, word_data = 0, word_address = 0, read_data = 0.
- Reset also sends the RX FSM to IDLE, clears the byte counter and clears the write pointer.
- Reset does not clear memory contents.
- A reset mid-frame or mid-word discards the partial byte or word.
- rx passes through a two-flop synchronizer before any use.
- RX FSM IDLE: on synchronized rx = 0, go to START and clear the bit timer.
- RX FSM START: at CLKS_PER_BIT/2 cycles, resample. If still 0, go to DATA with the timer cleared. If 1 (glitch), return to IDLE.
- RX FSM DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register. After bit 7, go to STOP.
- RX FSM STOP: sample after CLKS_PER_BIT cycles.
  - Sampled 1: byte_data <= shift register, pulse byte_valid for one cycle, go to IDLE.
  - Sampled 0 (framing error): no pulse; go to WAIT_IDLE until rx = 1, then go to IDLE.
- The receiver runs regardless of load_enable.
- Decoder, when load_enable = 0: byte counter and write pointer are held at 0. byte_valid pulses are ignored; no words are formed and no writes occur.
- Decoder, on byte_valid with load_enable = 1: shift word <= {word[23:0], byte_data}, then increment the byte counter.
- When the counter wraps 3 to 0:
  - word_data <= the completed word.
  - word_address <= write pointer.
  - Pulse word_valid the cycle after the fourth byte_valid.
  - Write pointer += 4, wrapping to 0 at MEM_WORDS*4.
- Memory: single write port. When word_valid = 1, mem[word_address[log2(MEM_WORDS)+1:2]] <= word_data.
- Read: read_data <= mem[read_address[log2(MEM_WORDS)+1:2]] every cycle, giving one-cycle latency.
- Read and write to the same word in the same cycle: read_data returns the old data.
- Address bits above the memory index are ignored (aliasing).
- Latency: byte_valid pulses about 9.5 bit times after the start-bit falling edge.

Decomposition:
- Shared package: CLKS_PER_BIT computation function and the RX state enum (IDLE, START, DATA, STOP, WAIT_IDLE).
- One natural sub-module: uart_rx (synchronizer plus FSM, producing byte_valid and byte_data).
- Byte packing and memory stay in the top module.

Test Plan:
- load_enable = 1; send bytes 00,40,00,93,00,80,01,13.
  - Exactly two word_valid pulses: 0x00400093 at address 0, then 0x00800113 at address 4.
  - Afterwards, read_address 0 gives read_data 0x00400093 one cycle later; read_address 6 gives 0x00800113.
- Single frame 0xA5:
  - One byte_valid pulse with byte_data = 0xA5.
  - Pulse occurs 9.5 × 694 ± 3 cycles after the falling edge.
- Low glitch on rx of 200 cycles in IDLE: no byte_valid, FSM back in IDLE. Then send 0x3C and receive 0x3C correctly.
- Frame 0x55 with stop bit driven 0:
  - No byte_valid.
  - Next valid frame 0x12 (after rx returns high) is received correctly.
  - Byte counter is unaffected by the bad frame.
- load_enable = 0, send 4 bytes: byte_valid pulses four times, no word_valid, memory word 0 unchanged. Then raise load_enable and send 11,22,33,44: 0x11223344 is written at address 0.
- Send 2 bytes, assert reset for 1 cycle, then send 4 bytes AA,BB,CC,DD: a single word 0xAABBCCDD at address 0.
